// File: rtl/four_bit_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// controller state encoding and the full-adder cell used by the trial subtractor.
package four_bit_divider_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Quotient reported when the captured divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        logic sum;
        logic cout;
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
        return {cout, sum};
    endfunction

endpackage

// File: rtl/four_bit_divider_if.sv
// Start/done request bus between board-level logic and the divider.
interface four_bit_divider_if
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

endinterface

// File: rtl/four_bit_divider_trial_subtractor.sv
// Combinational WIDTH+1 bit trial subtraction r - {0,d}, built as a ripple
// full-adder chain with d inverted and carry-in tied high.
module trial_subtractor
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    logic [WIDTH:0]   b_inv_s;
    logic [WIDTH+1:0] carry_s;

    assign b_inv_s    = ~{1'b0, d};
    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign {carry_s[i+1], diff[i]} = full_add(r[i], b_inv_s[i], carry_s[i]);
    end

    // No carry out of the top cell means r < d.
    assign borrow = ~carry_s[WIDTH+1];

endmodule

// File: rtl/four_bit_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, start/done
// handshake, results held until the next accepted request.
module four_bit_divider
    import four_bit_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    four_bit_divider_if.slave bus
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   r_shift_s;
    logic [WIDTH-1:0] q_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;
    logic [WIDTH:0]   r_next_s;
    logic [WIDTH-1:0] q_next_s;

    assign r_shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_shift_s = {q_q[WIDTH-2:0], 1'b0};

    trial_subtractor #(
        .WIDTH (WIDTH)
    ) u_trial (
        .r      (r_shift_s),
        .d      (d_q),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    // Restoring step: keep the difference only when the trial did not borrow.
    always_comb begin
        if (borrow_s) begin
            r_next_s = r_shift_s;
            q_next_s = q_shift_s;
        end else begin
            r_next_s = diff_s;
            q_next_s = q_shift_s | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Controller next state, datapath loads and registered-output next values.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    if (bus.divisor != {WIDTH{1'b0}}) begin
                        q_d     = bus.dividend;
                        d_d     = bus.divisor;
                        r_d     = {(WIDTH+1){1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_RUN;
                    end else begin
                        quot_d  = DBZ_QUOTIENT;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                r_d   = r_next_s;
                q_d   = q_next_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quot_d  = q_next_s;
                    rem_d   = r_next_s[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers; reset wins over any request.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r_q     <= {(WIDTH+1){1'b0}};
            q_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// directed scenarios with literal expectations and a randomized stream.
module tb_four_bit_divider;
    import four_bit_divider_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    four_bit_divider_if #(.WIDTH(4)) bus ();

    four_bit_divider #(.WIDTH(4)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    // Reference model state: cycles of busy left, pending result, visible result.
    logic       m_valid = 1'b0;
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [3:0] m_q = 4'd0, m_r = 4'd0, m_pq = 4'd0, m_pr = 4'd0;
    logic       m_dbz = 1'b0;
    logic [3:0] m_ca = 4'd0, m_cb = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edge the design samples its inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_left  <= 0;
            m_done  <= 1'b0;
            m_q     <= 4'd0;
            m_r     <= 4'd0;
            m_dbz   <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_q    <= m_pq;
                m_r    <= m_pr;
                m_dbz  <= 1'b0;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_ca <= bus.dividend;
                m_cb <= bus.divisor;
                if (bus.divisor == 4'd0) begin
                    m_done <= 1'b1;
                    m_q    <= 4'hF;
                    m_r    <= bus.dividend;
                    m_dbz  <= 1'b1;
                end else begin
                    m_left <= 4;
                    m_pq   <= bus.dividend / bus.divisor;
                    m_pr   <= bus.dividend % bus.divisor;
                end
            end
        end
    end

    // Compare every cycle, mid-period, once the model has seen reset.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(bus.busy), 32'(m_left > 0));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("quotient", 32'(bus.quotient), 32'(m_q));
            chk("remainder", 32'(bus.remainder), 32'(m_r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (m_cb != 4'd0) begin
                    chk("inv_eq", 32'(int'(bus.quotient) * int'(m_cb) + int'(bus.remainder)), 32'(m_ca));
                    chk("inv_lt", 32'(bus.remainder < m_cb), 32'd1);
                end else begin
                    chk("dbz_rem", 32'(bus.remainder), 32'(m_ca));
                end
            end
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // Called just after an edge; leaves just after the edge ending the DONE cycle.
    task automatic run_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                           input logic [3:0] er, input logic edz, input int elat, input string name);
        int lat;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(lat);
        chk({name, "_lat"}, 32'(lat), 32'(elat));
        chk({name, "_q"}, 32'(bus.quotient), 32'(eq));
        chk({name, "_r"}, 32'(bus.remainder), 32'(er));
        chk({name, "_dbz"}, 32'(bus.div_by_zero), 32'(edz));
        @(posedge clk); #2;
    endtask

    initial begin
        int lat;
        int dc0;
        bus.start = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor = 4'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_q", 32'(bus.quotient), 32'd0);
        chk("rst_r", 32'(bus.remainder), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clk); #2;

        run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "d13_3");
        run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, "d15_1");
        run_div(4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 5, "d5_7");
        run_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1, "d9_0");

        // A start pulse during RUN must be ignored.
        dc0 = done_cnt;
        bus.dividend = 4'd12; bus.divisor = 4'd5; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(posedge clk); #2;
        bus.dividend = 4'd1; bus.divisor = 4'd1; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_done(lat);
        chk("ign_q", 32'(bus.quotient), 32'd2);
        chk("ign_r", 32'(bus.remainder), 32'd2);
        repeat (6) @(posedge clk);
        #2;
        chk("ign_pulses", 32'(done_cnt - dc0), 32'd1);

        // Start held through DONE: next run follows with no IDLE cycle.
        bus.dividend = 4'd14; bus.divisor = 4'd4; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.dividend = 4'd7; bus.divisor = 4'd2;
        wait_done(lat);
        chk("b2b1_lat", 32'(lat), 32'd5);
        chk("b2b1_q", 32'(bus.quotient), 32'd3);
        chk("b2b1_r", 32'(bus.remainder), 32'd2);
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        chk("b2b2_lat", 32'(lat), 32'd4);
        chk("b2b2_q", 32'(bus.quotient), 32'd3);
        chk("b2b2_r", 32'(bus.remainder), 32'd1);
        @(posedge clk); #2;

        // Reset on the second RUN cycle aborts without a done pulse.
        dc0 = done_cnt;
        bus.dividend = 4'd11; bus.divisor = 4'd2; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_q", 32'(bus.quotient), 32'd0);
        chk("abort_r", 32'(bus.remainder), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort_pulses", 32'(done_cnt - dc0), 32'd0);
        @(posedge clk); #2;
        run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5, "d11_2");

        // Exhaustive operand sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    run_div(4'(a), 4'd0, 4'd15, 4'(a), 1'b1, 1, "sweep");
                else
                    run_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 5, "sweep");
            end
        end

        // Randomized request stream with occasional resets; the model checks it.
        for (int i = 0; i < 800; i++) begin
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = 4'($urandom_range(0, 15));
            bus.divisor  = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            reset        = ($urandom_range(0, 63) == 0);
            @(posedge clk); #2;
        end
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
